// File: rtl/corr_result_streamer.sv
// Frame FIFO + AXI-stream serialiser for correlator result sets.
// Each accepted set is sent as five words: sequence number, r11, r22, r12_re, r12_im.
module corr_result_streamer #(
  parameter int DIN_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DIN_WIDTH-1:0]            r12_re,
  input  logic [DIN_WIDTH-1:0]            r12_im,
  input  logic [DIN_WIDTH-1:0]            r11,
  input  logic [DIN_WIDTH-1:0]            r22,
  input  logic                            din_valid,
  output logic [DIN_WIDTH-1:0]            m_tdata,
  output logic [2:0]                      m_tuser,
  output logic                            m_tlast,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic [CNT_WIDTH-1:0]            drop_count,
  output logic                            overflow,
  input  logic                            clear_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = 5 * DIN_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  // Handshake: a word transfers on a rising clk edge where m_tvalid & m_tready;
  // once m_tvalid is high the word is held until that transfer (or rst).

  state_t                state_q, state_d;
  logic [FW-1:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [DIN_WIDTH-1:0]  seq;
  logic                  full, wr_en, drop, hs, pop;
  logic [FW-1:0]         head;
  logic [DIN_WIDTH-1:0]  next_seq_word;
  logic                  tvalid_d, tlast_d;
  logic [DIN_WIDTH-1:0]  tdata_d;
  logic [2:0]            tuser_d;

  function automatic logic [DIN_WIDTH-1:0] word_sel(input logic [FW-1:0] f, input logic [2:0] k);
    case (k)
      3'd0:    return f[0*DIN_WIDTH +: DIN_WIDTH];
      3'd1:    return f[1*DIN_WIDTH +: DIN_WIDTH];
      3'd2:    return f[2*DIN_WIDTH +: DIN_WIDTH];
      3'd3:    return f[3*DIN_WIDTH +: DIN_WIDTH];
      default: return f[4*DIN_WIDTH +: DIN_WIDTH];
    endcase
  endfunction

  // Full is judged on the registered level, so a same-cycle pop cannot save a write.
  assign full          = (fifo_level == LW'(FIFO_DEPTH));
  assign wr_en         = din_valid & ~full;
  assign drop          = din_valid & full;
  assign hs            = m_tvalid & m_tready;
  assign pop           = hs & (m_tuser == 3'd4);
  assign rd_ptr_nxt    = rd_ptr + 1'b1;
  assign head          = mem[rd_ptr];
  assign next_seq_word = mem[rd_ptr_nxt][DIN_WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    tvalid_d = m_tvalid;
    tdata_d  = m_tdata;
    tuser_d  = m_tuser;
    tlast_d  = m_tlast;
    case (state_q)
      IDLE: begin
        // Empty FIFO: the incoming set's header bypasses storage for 1-cycle latency.
        if (wr_en) begin
          state_d  = SEND;
          tvalid_d = 1'b1;
          tdata_d  = seq;
          tuser_d  = 3'd0;
          tlast_d  = 1'b0;
        end
      end
      SEND: begin
        if (m_tready) begin
          if (m_tuser != 3'd4) begin
            tuser_d = m_tuser + 3'd1;
            tdata_d = word_sel(head, m_tuser + 3'd1);
            tlast_d = (m_tuser == 3'd3);
          end else if (fifo_level > LW'(1)) begin
            tuser_d = 3'd0;
            tdata_d = next_seq_word;
            tlast_d = 1'b0;
          end else if (wr_en) begin
            tuser_d = 3'd0;
            tdata_d = seq;
            tlast_d = 1'b0;
          end else begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tuser_d  = 3'd0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_ptr] <= {r12_im, r12_re, r22, r11, seq};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      m_tvalid   <= 1'b0;
      m_tdata    <= '0;
      m_tuser    <= 3'd0;
      m_tlast    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      seq        <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q  <= state_d;
      m_tvalid <= tvalid_d;
      m_tdata  <= tdata_d;
      m_tuser  <= tuser_d;
      m_tlast  <= tlast_d;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr_nxt;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (din_valid) seq <= seq + 1'b1;
      // A drop in the same cycle as a clear is still recorded.
      if (clear_overflow) begin
        drop_count <= drop ? CNT_WIDTH'(1) : '0;
        overflow   <= drop;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
    end
  end

endmodule
